s2p_bit_grouper: RTL and testbench

Parametrised successor to the two-bit serial-to-parallel stage in the 802.11a TX chain. It collects interleaved serial bits into N_BPSC-bit groups for the constellation mapper. Group width is selected at runtime by modulation mode: 1, 2, 4 or 6 bits for BPSK, QPSK, 16-QAM and 64-QAM. Completed groups are buffered in an internal FIFO and drained by the mapper through a read_en/data_out_valid handshake. A flush input zero-pads a trailing partial group at end of packet.

---
 rtl/s2p_bit_grouper.sv | 140 ++++++++++++++
 tb/tb_s2p_bit_grouper.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_bit_grouper.sv
`default_nettype none
// ============================================================================
// Module      : s2p_bit_grouper
// Description : Serial-to-parallel grouper that packs 1/2/4/6 serial bits into
//               mapper symbols and buffers them in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_bit_grouper #(
    parameter int MAX_W = 6,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             read_en,
    output logic [MAX_W-1:0] data_out,
    output logic             data_out_valid,
    output logic [CW-1:0]    fifo_count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int KW = $clog2(MAX_W);
    localparam int AW = $clog2(DEPTH);

    function automatic logic [KW-1:0] mode_width(input logic [1:0] m);
        case (m)
            2'd0:    return KW'(1);
            2'd1:    return KW'(2);
            2'd2:    return KW'(4);
            default: return KW'(6);
        endcase
    endfunction

    logic [MAX_W-1:0] acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    width_q, width_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [MAX_W-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic [MAX_W-1:0] mem_q [DEPTH];

    logic [MAX_W-1:0] w_acc_next;
    logic [KW-1:0]    w_k_next;
    logic [KW-1:0]    w_width;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_complete;
    logic             w_flush_push;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_full   = (count_q == CW'(DEPTH));
        w_empty  = (count_q == '0);
        w_accept = data_in_valid && !w_full;
        // Width is taken from mode only on the first bit of a group.
        w_width  = (k_q == '0) ? mode_width(mode) : width_q;

        w_acc_next = acc_q;
        if (w_accept) begin
            w_acc_next[k_q] = data_in;
        end
        w_k_next = w_accept ? (k_q + KW'(1)) : k_q;

        w_complete   = w_accept && (k_q == (w_width - KW'(1)));
        // Accumulator bits above k are always zero, so a flushed group is
        // already zero-padded.
        w_flush_push = flush && !w_full && !w_complete && (w_k_next != '0);
        w_push       = w_complete || w_flush_push;
        w_pop        = read_en && !w_empty;

        width_d = (w_accept && (k_q == '0)) ? w_width : width_q;
        acc_d   = w_push ? '0 : w_acc_next;
        k_d     = w_push ? '0 : w_k_next;

        wr_ptr_d = w_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        data_out_d = w_pop ? mem_q[rd_ptr_q] : data_out_q;
        valid_d    = w_pop;
        overflow_d = overflow_q || (w_full && (data_in_valid || flush));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            k_q        <= '0;
            width_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            k_q        <= k_d;
            width_q    <= width_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            mem_q[wr_ptr_q] <= w_acc_next;
        end
    end

    assign data_in_ready  = !w_full;
    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign fifo_count     = count_q;
    assign empty          = w_empty;
    assign full           = w_full;
    assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_s2p_bit_grouper.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2p_bit_grouper
// Description : Directed scoreboard bench for s2p_bit_grouper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2p_bit_grouper;

    localparam int MAX_W = 6;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             data_in = 1'b0;
    logic             data_in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             read_en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             data_in_ready;
    logic [MAX_W-1:0] data_out;
    logic             data_out_valid;
    logic [CW-1:0]    fifo_count;
    logic             empty;
    logic             full;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [MAX_W-1:0] sb_q [$];

    logic b1 [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic b2 [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    s2p_bit_grouper #(.MAX_W(MAX_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .mode           (mode),
        .flush          (flush),
        .read_en        (read_en),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .fifo_count     (fifo_count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [MAX_W-1:0] obs, input logic [MAX_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        data_in_valid = 1'b1;
        data_in       = b;
        tick();
    endtask

    // One read_en pulse, then compare against the oldest scoreboard entry.
    task automatic read_check(input string tag);
        logic [MAX_W-1:0] exp;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk1({tag, "_valid"}, data_out_valid, 1'b1);
        if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s_sb observed=read expected=no_pending_group", tag);
        end else begin
            exp = sb_q.pop_front();
            chkw({tag, "_data"}, data_out, exp);
        end
    endtask

    initial begin
        logic b;
        logic prev;
        logic [MAX_W-1:0] e;
        prev = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chkc("rst_count", fifo_count, CW'(0));
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_full", full, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_valid", data_out_valid, 1'b0);
        chkw("rst_data", data_out, '0);
        chk1("rst_ready", data_in_ready, 1'b1);

        // QPSK pairs with continuous valid
        mode = 2'd1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) sb_q.push_back(6'h01);
            if (i == 3) sb_q.push_back(6'h03);
            if (i == 5) sb_q.push_back(6'h00);
            send_bit(b1[i]);
            if (i % 2 == 1) chkc("t1_count_up", fifo_count, CW'((i + 1) / 2));
        end
        data_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_check("t1_read");
            chkc("t1_count_dn", fifo_count, CW'(2 - i));
        end
        tick();
        chk1("t1_pulse", data_out_valid, 1'b0);

        // 64-QAM with a mid-group mode change
        mode = 2'd3;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) mode = 2'd0;
            if (i == 6) mode = 2'd3;
            if (i == 5) sb_q.push_back(6'h0D);
            if (i == 11) sb_q.push_back(6'h1E);
            send_bit(b2[i]);
            if (i == 4) chkc("t2_midgroup_count", fifo_count, CW'(0));
            if (i == 5) chkc("t2_first_group", fifo_count, CW'(1));
        end
        data_in_valid = 1'b0;
        read_check("t2_read0");
        read_check("t2_read1");

        // 16-QAM partial group flush
        mode = 2'd2;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        data_in_valid = 1'b0;
        sb_q.push_back(6'h07);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkc("t3_flush_count", fifo_count, CW'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkc("t3_noop_flush", fifo_count, CW'(1));
        read_check("t3_read");
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk1("t3_empty_read_valid", data_out_valid, 1'b0);
        chkw("t3_empty_read_hold", data_out, 6'h07);
        chk1("t3_empty", empty, 1'b1);

        // Flush together with a group-completing bit: exactly one push
        mode = 2'd1;
        send_bit(1'b1);
        sb_q.push_back(6'h03);
        data_in = 1'b1;
        flush   = 1'b1;
        tick();
        flush         = 1'b0;
        data_in_valid = 1'b0;
        chkc("t3_flush_complete", fifo_count, CW'(1));
        // Flush together with a non-completing bit: bit included, then padding
        mode = 2'd2;
        send_bit(1'b1);
        send_bit(1'b0);
        sb_q.push_back(6'h05);
        data_in = 1'b1;
        flush   = 1'b1;
        tick();
        flush         = 1'b0;
        data_in_valid = 1'b0;
        chkc("t3_flush_partial", fifo_count, CW'(2));
        read_check("t3_read_fc");
        read_check("t3_read_fp");

        // BPSK fill to full, then overflow
        mode = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            b = ((i % 3) == 0) || (i == 7);
            sb_q.push_back({{(MAX_W-1){1'b0}}, b});
            send_bit(b);
        end
        data_in_valid = 1'b0;
        chk1("t4_full", full, 1'b1);
        chk1("t4_ready", data_in_ready, 1'b0);
        chkc("t4_count", fifo_count, CW'(DEPTH));
        chk1("t4_no_overflow_yet", overflow, 1'b0);
        send_bit(1'b1);
        data_in_valid = 1'b0;
        chk1("t4_overflow", overflow, 1'b1);
        chkc("t4_count_after_drop", fifo_count, CW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            read_check("t4_read");
        end
        chk1("t4_empty", empty, 1'b1);
        chk1("t4_overflow_sticky", overflow, 1'b1);

        // Reset mid-group with stored groups
        mode = 2'd1;
        for (int i = 0; i < 10; i++) begin
            send_bit(i[0] ^ i[2]);
        end
        mode = 2'd3;
        send_bit(1'b1);
        send_bit(1'b1);
        data_in_valid = 1'b0;
        chkc("t5_pre_reset_count", fifo_count, CW'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        chkc("t5_count", fifo_count, CW'(0));
        chk1("t5_empty", empty, 1'b1);
        chk1("t5_overflow", overflow, 1'b0);
        chk1("t5_valid", data_out_valid, 1'b0);
        mode = 2'd1;
        send_bit(1'b1);
        sb_q.push_back(6'h01);
        send_bit(1'b0);
        data_in_valid = 1'b0;
        chkc("t5_fresh_count", fifo_count, CW'(1));
        read_check("t5_fresh_read");

        // Steady QPSK stream, read coinciding with every push
        mode = 2'd1;
        for (int i = 0; i < 96; i++) begin
            b = 1'($urandom_range(0, 1));
            if (i % 2 == 1) begin
                sb_q.push_back({{(MAX_W-2){1'b0}}, b, prev});
                read_en = 1'b1;
            end else begin
                read_en = 1'b0;
            end
            prev = b;
            send_bit(b);
            if (i % 2 == 1) begin
                chkc("t6_count", fifo_count, CW'(1));
                if (i >= 3) begin
                    chk1("t6_valid", data_out_valid, 1'b1);
                    e = sb_q.pop_front();
                    chkw("t6_data", data_out, e);
                end
            end
        end
        data_in_valid = 1'b0;
        read_en       = 1'b0;
        read_check("t6_last");
        chk1("t6_empty", empty, 1'b1);
        chk1("t6_overflow", overflow, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
